// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin shared double-dabble binary-to-BCD converter for two requesters
// Ports: clk, reset (sync, active-high); req0/data0, req1/data1 level requests sampled at grant;
//        gnt0/gnt1 one-cycle grant pulses; busy during conversion; done one-cycle result pulse;
//        owner/bcd hold the tagged result between done pulses.
module bcd_convert_arbiter #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [WIDTH-1:0]      data0,
  input  logic                  req1,
  input  logic [WIDTH-1:0]      data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  busy,
  output logic                  done,
  output logic                  owner,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, CONVERT} state_t;
  state_t state, state_n;
  logic [SW-1:0] sr, adj;
  logic [CW-1:0] cnt;
  logic cur_owner, last_owner, take, win, fin;
  // win is the requester index; on contention the one that did not own the last result goes
  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++)
      adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] >= 4'd5 ? sr[WIDTH+4*i +: 4] + 4'd3 : sr[WIDTH+4*i +: 4];
    take = state == IDLE && (req0 || req1);
    win = req0 && req1 ? ~last_owner : req1;
    fin = state == CONVERT && cnt == CW'(WIDTH - 1);
    state_n = take ? CONVERT : fin ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  assign busy = state == CONVERT;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      cur_owner <= 1'b0;
      last_owner <= 1'b1;
      owner <= 1'b0;
      bcd <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
    end else begin
      gnt0 <= take && !win;
      gnt1 <= take && win;
      done <= fin;
      if (take) begin
        sr <= {{BW{1'b0}}, win ? data1 : data0};
        cur_owner <= win;
        cnt <= '0;
      end else if (state == CONVERT) begin
        sr <= {adj[SW-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end
      if (fin) begin
        bcd <= adj[SW-2:WIDTH-1];
        owner <= cur_owner;
        last_owner <= cur_owner;
      end
    end
  end
endmodule
